// File: rtl/avaliador_de_acertos.sv
// Note lane scroller and hit judge for the rhythm game: shifts lane-mask commands
// towards the judge stage, scores player presses against it, tracks combo and score.
module avaliador_de_acertos #(
  parameter int DEPTH       = 4,
  parameter int PONTOS_BASE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [3:0]           comando,
  input  logic [3:0]           KEY,
  input  logic                 iniciar,
  input  logic                 fim_de_jogo,
  output logic [4*DEPTH-1:0]   linhas,
  output logic [3:0]           alvo_acertado,
  output logic [15:0]          pontos,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic                 acerto,
  output logic                 erro,
  output logic [1:0]           estado
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [4*DEPTH-1:0]   linhas_q, linhas_d;
  logic [3:0]           alvo_q, alvo_d;
  logic [15:0]          pontos_q, pontos_d;
  logic [7:0]           combo_q, combo_d;
  logic [7:0]           max_combo_q, max_combo_d;
  logic                 acerto_q, acerto_d;
  logic                 erro_q, erro_d;
  logic [3:0]           key_s1_q, key_s1_d;
  logic [3:0]           key_s2_q, key_s2_d;
  logic [3:0]           key_s3_q, key_s3_d;

  logic [3:0]           press;
  logic [3:0]           juiz;
  logic [3:0]           flags;
  logic [2:0]           mult;
  logic [16:0]          soma;
  logic [7:0]           combo_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= IDLE;
      linhas_q    <= '0;
      alvo_q      <= '0;
      pontos_q    <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      key_s1_q    <= 4'hF;
      key_s2_q    <= 4'hF;
      key_s3_q    <= 4'hF;
    end else begin
      estado_q    <= estado_d;
      linhas_q    <= linhas_d;
      alvo_q      <= alvo_d;
      pontos_q    <= pontos_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_s3_q    <= key_s3_d;
    end
  end

  // s1/s2 synchronize the buttons; s3 holds the previous synchronized value for edge detection
  always_comb begin
    key_s1_d = KEY;
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    press    = (estado_q == RUN) ? (key_s3_q & ~key_s2_q) : 4'h0;
  end

  always_comb begin
    juiz  = linhas_q[4*DEPTH-1 -: 4];
    flags = alvo_q | (press & juiz);
    if (combo_q >= 8'd24)      mult = 3'd4;
    else if (combo_q >= 8'd16) mult = 3'd3;
    else if (combo_q >= 8'd8)  mult = 3'd2;
    else                       mult = 3'd1;
    soma      = {1'b0, pontos_q} + (17'(PONTOS_BASE) * 17'(mult));
    combo_inc = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
  end

  always_comb begin
    estado_d    = estado_q;
    linhas_d    = linhas_q;
    alvo_d      = alvo_q;
    pontos_d    = pontos_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    acerto_d    = 1'b0;
    erro_d      = 1'b0;
    case (estado_q)
      IDLE: begin
        linhas_d    = '0;
        alvo_d      = '0;
        pontos_d    = '0;
        combo_d     = '0;
        max_combo_d = '0;
        if (iniciar) estado_d = RUN;
      end
      RUN: begin
        if (tick) begin
          // Presses in a tick cycle only ever credit the outgoing note
          linhas_d = {linhas_q[4*DEPTH-5:0], comando};
          alvo_d   = '0;
          if (juiz != 4'h0) begin
            if (flags == juiz) begin
              acerto_d    = 1'b1;
              pontos_d    = soma[16] ? 16'hFFFF : soma[15:0];
              combo_d     = combo_inc;
              max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
            end else begin
              erro_d  = 1'b1;
              combo_d = '0;
            end
          end
        end else if (press != 4'h0) begin
          alvo_d = alvo_q | (press & juiz);
          if ((press & ~juiz) != 4'h0) begin
            erro_d  = 1'b1;
            combo_d = '0;
          end
        end
        if (fim_de_jogo) estado_d = DONE;
      end
      DONE: begin
        if (iniciar) begin
          linhas_d    = '0;
          alvo_d      = '0;
          pontos_d    = '0;
          combo_d     = '0;
          max_combo_d = '0;
          estado_d    = RUN;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  assign linhas        = linhas_q;
  assign alvo_acertado = alvo_q;
  assign pontos        = pontos_q;
  assign combo         = combo_q;
  assign max_combo     = max_combo_q;
  assign acerto        = acerto_q;
  assign erro          = erro_q;
  assign estado        = estado_q;

endmodule

// File: tb/tb_avaliador_de_acertos.sv
// Bench for avaliador_de_acertos: directed game scenarios plus random play, every cycle
// compared against a note-level reference model of the scoring rules.
module tb_avaliador_de_acertos;
  localparam int DEPTH = 4;
  localparam int BASE  = 10;

  logic               clk = 1'b0;
  logic               rst_r = 1'b1;
  logic               tick_r = 1'b0;
  logic [3:0]         comando_r = 4'h0;
  logic [3:0]         key_r = 4'hF;
  logic               iniciar_r = 1'b0;
  logic               fim_r = 1'b0;
  logic [4*DEPTH-1:0] linhas;
  logic [3:0]         alvo_acertado;
  logic [15:0]        pontos;
  logic [7:0]         combo, max_combo;
  logic               acerto, erro;
  logic [1:0]         estado;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] m_lanes [DEPTH];
  logic [3:0] m_alvo;
  int         m_pontos, m_combo, m_max, m_estado;
  logic       m_acerto, m_erro;
  logic [3:0] key_hist [$];

  avaliador_de_acertos #(.DEPTH(DEPTH), .PONTOS_BASE(BASE)) dut (
    .clk(clk), .rst(rst_r), .tick(tick_r), .comando(comando_r), .KEY(key_r),
    .iniciar(iniciar_r), .fim_de_jogo(fim_r), .linhas(linhas),
    .alvo_acertado(alvo_acertado), .pontos(pontos), .combo(combo),
    .max_combo(max_combo), .acerto(acerto), .erro(erro), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) m_lanes[k] = 4'h0;
    m_alvo = 4'h0; m_pontos = 0; m_combo = 0; m_max = 0;
  endtask

  task automatic model_hit();
    int mult;
    mult = (m_combo / 8) + 1;
    if (mult > 4) mult = 4;
    m_pontos = m_pontos + BASE * mult;
    if (m_pontos > 65535) m_pontos = 65535;
    if (m_combo < 255) m_combo = m_combo + 1;
    if (m_combo > m_max) m_max = m_combo;
    m_acerto = 1'b1;
  endtask

  task automatic model_miss();
    m_erro  = 1'b1;
    m_combo = 0;
  endtask

  // A press registers when the button, seen two clocks late, goes from released to held
  task automatic model_edge();
    logic [3:0] press, m, flags;
    press = key_hist[0] & ~key_hist[1];
    key_hist.push_back(key_r);
    void'(key_hist.pop_front());
    m_acerto = 1'b0;
    m_erro   = 1'b0;
    if (rst_r) begin
      model_clear();
      m_estado = 0;
      key_hist = '{4'hF, 4'hF, 4'hF};
      return;
    end
    case (m_estado)
      0: if (iniciar_r) m_estado = 1;
      1: begin
        m = m_lanes[DEPTH-1];
        if (tick_r) begin
          flags = m_alvo | (press & m);
          for (int k = DEPTH-1; k > 0; k--) m_lanes[k] = m_lanes[k-1];
          m_lanes[0] = comando_r;
          m_alvo = 4'h0;
          if (m != 4'h0) begin
            if (flags == m) model_hit();
            else model_miss();
          end
        end else if (press != 4'h0) begin
          m_alvo = m_alvo | (press & m);
          if ((press & ~m) != 4'h0) model_miss();
        end
        if (fim_r) m_estado = 2;
      end
      default: if (iniciar_r) begin
        model_clear();
        m_estado = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [4*DEPTH-1:0] exp_linhas;
    for (int k = 0; k < DEPTH; k++) exp_linhas[4*k +: 4] = m_lanes[k];
    check("linhas", 32'(linhas), 32'(exp_linhas));
    check("alvo", 32'(alvo_acertado), 32'(m_alvo));
    check("pontos", 32'(pontos), 32'(m_pontos));
    check("combo", 32'(combo), 32'(m_combo));
    check("max_combo", 32'(max_combo), 32'(m_max));
    check("acerto", 32'(acerto), 32'(m_acerto));
    check("erro", 32'(erro), 32'(m_erro));
    check("estado", 32'(estado), 32'(m_estado));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    tick_r    = 1'b0;
    iniciar_r = 1'b0;
  endtask

  task automatic do_tick(input logic [3:0] cmd);
    comando_r = cmd;
    tick_r    = 1'b1;
    step();
  endtask

  // Hold buttons for two clocks; the press lands on the third clock, optionally with a tick
  task automatic press_keys(input logic [3:0] mask, input logic with_tick, input logic [3:0] cmd);
    key_r = ~mask;
    step();
    step();
    key_r = 4'hF;
    if (with_tick) begin
      tick_r    = 1'b1;
      comando_r = cmd;
    end
    step();
  endtask

  // Feeds n single-lane notes into an empty lane and hits each one as it leaves
  task automatic hit_stream(input int n);
    for (int t = 0; t < n + DEPTH; t++) begin
      press_keys((t >= DEPTH) ? 4'h1 : 4'h0, 1'b1, (t < n) ? 4'h1 : 4'h0);
    end
  endtask

  initial begin
    model_clear();
    m_estado = 0; m_acerto = 1'b0; m_erro = 1'b0;
    key_hist = '{4'hF, 4'hF, 4'hF};

    rst_r = 1'b1;
    step();
    step();
    rst_r = 1'b0;
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_pontos", 32'(pontos), 32'd0);

    for (int i = 0; i < 3; i++) do_tick(4'h1);
    check("idle_linhas", 32'(linhas), 32'd0);

    iniciar_r = 1'b1;
    step();
    check("start_estado", 32'(estado), 32'd1);

    // clean hit on lanes 0 and 1
    do_tick(4'b0011);
    for (int i = 0; i < 3; i++) do_tick(4'h0);
    press_keys(4'b0011, 1'b0, 4'h0);
    check("hit_alvo", 32'(alvo_acertado), 32'h3);
    do_tick(4'h0);
    check("hit_acerto", 32'(acerto), 32'd1);
    check("hit_pontos", 32'(pontos), 32'd10);
    check("hit_combo", 32'(combo), 32'd1);
    check("hit_max", 32'(max_combo), 32'd1);

    // partial press on 0101
    do_tick(4'b0101);
    for (int i = 0; i < 3; i++) do_tick(4'h0);
    press_keys(4'b0001, 1'b0, 4'h0);
    do_tick(4'h0);
    check("partial_erro", 32'(erro), 32'd1);
    check("partial_combo", 32'(combo), 32'd0);
    check("partial_pontos", 32'(pontos), 32'd10);

    // untouched note
    do_tick(4'b0001);
    for (int i = 0; i < 3; i++) do_tick(4'h0);
    do_tick(4'h0);
    check("missed_erro", 32'(erro), 32'd1);

    // wrong lane between ticks, then the right one
    do_tick(4'b0001);
    for (int i = 0; i < 3; i++) do_tick(4'h0);
    press_keys(4'b1000, 1'b0, 4'h0);
    check("wrong_erro", 32'(erro), 32'd1);
    check("wrong_combo", 32'(combo), 32'd0);
    press_keys(4'b0001, 1'b0, 4'h0);
    do_tick(4'h0);
    check("after_wrong_acerto", 32'(acerto), 32'd1);
    check("after_wrong_pontos", 32'(pontos), 32'd20);

    // game over freezes everything
    fim_r = 1'b1;
    step();
    fim_r = 1'b0;
    check("done_estado", 32'(estado), 32'd2);
    press_keys(4'b0001, 1'b1, 4'h1);
    check("done_pontos", 32'(pontos), 32'd20);
    check("done_linhas", 32'(linhas), 32'd0);
    check("done_acerto", 32'(acerto), 32'd0);

    iniciar_r = 1'b1;
    step();
    check("restart_estado", 32'(estado), 32'd1);
    check("restart_pontos", 32'(pontos), 32'd0);
    check("restart_max", 32'(max_combo), 32'd0);

    // multiplier: presses land in the tick cycle
    hit_stream(9);
    check("mult_pontos", 32'(pontos), 32'd100);
    check("mult_combo", 32'(combo), 32'd9);

    hit_stream(1700);
    check("sat_pontos", 32'(pontos), 32'hFFFF);
    check("sat_combo", 32'(combo), 32'd255);
    check("sat_max", 32'(max_combo), 32'd255);

    press_keys(4'b0010, 1'b0, 4'h0);
    check("pause_press_erro", 32'(erro), 32'd1);
    check("pause_press_combo", 32'(combo), 32'd0);
    check("pause_press_max", 32'(max_combo), 32'd255);

    // random play
    for (int i = 0; i < 600; i++) begin
      rst_r     = ($urandom_range(0, 249) == 0);
      tick_r    = ($urandom_range(0, 3) == 0);
      comando_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) key_r = 4'($urandom_range(0, 15));
      iniciar_r = ($urandom_range(0, 19) == 0);
      fim_r     = ($urandom_range(0, 59) == 0);
      step();
    end
    rst_r = 1'b0; fim_r = 1'b0; key_r = 4'hF;
    for (int i = 0; i < 3; i++) step();

    // reset in the middle of a game
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    iniciar_r = 1'b1;
    step();
    for (int i = 0; i < 3; i++) do_tick(4'($urandom_range(1, 15)));
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    check("midrst_estado", 32'(estado), 32'd0);
    check("midrst_linhas", 32'(linhas), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
